ysyx_25020051_ifetch_sram: RTL and testbench
============================================

YSYX_25020051_IFETCH_SRAM -- requirements
Module: ysyx_25020051_ifetch_sram

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide DATA_WIDTH, 32, instruction word width.
REQ-002 SHALL provide DEPTH_LOG2, 4, log2 of word count (16 words).
REQ-003 SHALL provide LATENCY, 2, clock edges from request accept to rsp_valid rise; legal 1..7.
REQ-004 SHALL provide BASE, 32'h80000000, byte address of word 0.

Ports (name, direction, width, meaning):
REQ-005 SHALL provide clk, input, 1, single clock; all state updates on posedge clk.
REQ-006 SHALL provide rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL provide req_valid, input, 1, fetch request present.
REQ-008 SHALL provide req_ready, output, 1, block can accept a request.
REQ-009 SHALL provide req_addr, input, 32, fetch byte address.
REQ-010 SHALL provide rsp_valid, output, 1, response present.
REQ-011 SHALL provide rsp_ready, input, 1, consumer takes the response.
REQ-012 SHALL provide rsp_data, output, DATA_WIDTH, fetched word.
REQ-013 SHALL provide rsp_err, output, 1, fetch fault flag.
REQ-014 SHALL provide ld_en, ld_idx (DEPTH_LOG2), and ld_data (DATA_WIDTH) as inputs forming a synchronous preload write port.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP, with one outstanding request at most.
REQ-016 SHALL drive req_ready=1 only in IDLE, decoded from state alone with no combinational path from rsp_ready.
REQ-017 SHALL accept a request on an edge where req_valid and req_ready are both 1, and latch the array word plus the error status at that edge.
REQ-018 SHALL index the word as (req_addr-BASE)>>2, truncated to DEPTH_LOG2 bits.
REQ-019 SHALL go IDLE->RESP on accept when LATENCY=1; otherwise it SHALL go IDLE->WAIT and load a down-counter with LATENCY-1.
REQ-020 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where the counter equals 1.
REQ-021 SHALL raise rsp_valid exactly LATENCY edges after the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready=1; on that edge it SHALL go RESP->IDLE.
REQ-023 SHALL NOT accept a new request on the edge where RESP completes; the minimum spacing between accepts is LATENCY+1 edges.
REQ-024 SHALL ignore req_valid in WAIT and RESP; requests are neither dropped nor queued.
REQ-025 SHALL write ld_data to ld_idx on an edge with ld_en=1, in any state.
REQ-026 SHALL return the pre-write word when ld_en targets the accepted index on the accept edge; later loads SHALL NOT alter a latched response.
REQ-027 SHALL drive rsp_data=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-028 SHALL, on rst=1 and independent of clk: set state=IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-029 SHALL drive req_ready=1 while in IDLE after reset.
REQ-030 SHALL abort any request in WAIT or RESP on rst=1, with no response produced afterwards.
REQ-031 SHALL NOT clear array contents on reset.

Configuration
REQ-032 SHALL, when YSYX_25020051_IFETCH_ERR_CHECK_EN is defined, set rsp_err=1 with rsp_data=0 for a misaligned address (req_addr[1:0]!=0) or an address outside BASE..BASE+4*2^DEPTH_LOG2-1; timing is unchanged.
REQ-033 SHALL, when YSYX_25020051_IFETCH_ERR_CHECK_EN is undefined, tie rsp_err to 0, ignore req_addr[1:0], and wrap out-of-range addresses per REQ-018.

Verification
REQ-034 SHALL cover: preload idx0=32'h00500093 and idx1=32'h00000013, LATENCY=2; request 0x80000004 -> rsp_valid 2 edges after accept, rsp_data=32'h00000013, rsp_err=0.
REQ-035 SHALL cover: rsp_ready held 0 for 3 cycles in RESP -> rsp_valid=1 and rsp_data=32'h00500093 stable, req_ready=0 throughout, then IDLE one edge after rsp_ready=1.
REQ-036 SHALL cover: with the macro, requests 0x80000002 and 0x80000040 -> rsp_err=1, rsp_data=0; without it, the same requests -> rsp_data=32'h00500093 for both, rsp_err=0.
REQ-037 SHALL cover: rst pulsed during WAIT -> rsp_valid stays 0 and req_ready=1 after release; a following request to 0x80000000 returns 32'h00500093.
REQ-038 SHALL cover: ld_en idx0 with 32'hDEADBEEF on the accept edge of request 0x80000000 -> response 32'h00500093; the next request returns 32'hDEADBEEF.
REQ-039 SHALL cover: LATENCY=1 and LATENCY=7 builds -> rsp_valid rises exactly 1 and 7 edges after accept, respectively.

Source files
------------

// File: rtl/ysyx_25020051_ifetch_sram.sv
// Single-outstanding instruction fetch port over a small preloadable word array with a fixed response latency.
// Optional address fault checking is enabled by defining YSYX_25020051_IFETCH_ERR_CHECK_EN.
module ysyx_25020051_ifetch_sram #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE       = 32'h80000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0] ld_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_reg;
  logic [2:0]            cnt_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [29:0]           word_off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_err;

  assign word_off = req_addr[31:2] - BASE[31:2];
  assign idx      = word_off[DEPTH_LOG2-1:0];

`ifdef YSYX_25020051_IFETCH_ERR_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (word_off[29:DEPTH_LOG2] != '0);
`else
  // Without checking, the low address bits and the out-of-range bits simply wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], word_off[29:DEPTH_LOG2]};
  assign addr_err = 1'b0;
`endif

  // Preload port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_valid_reg ? data_reg : '0;
  assign rsp_err   = rsp_valid_reg ? err_reg : 1'b0;

  // The accept edge counts as the first of the LATENCY edges before rsp_valid is seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      rsp_valid_reg <= 1'b0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            data_reg <= addr_err ? '0 : mem[idx];
            err_reg  <= addr_err;
            if (LATENCY == 1) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 3'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 3'd1) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            cnt_reg       <= 3'd0;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            data_reg      <= '0;
            err_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020051_ifetch_sram.sv
// Directed bench for ysyx_25020051_ifetch_sram: main instance at LATENCY=2, side instances at 1 and 7.
module tb_ysyx_25020051_ifetch_sram;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_l1, req_valid_l7;
  logic        rsp_ready, rsp_ready_l1, rsp_ready_l7;
  logic [31:0] req_addr;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;

  logic        req_ready, req_ready_l1, req_ready_l7;
  logic        rsp_valid, rsp_valid_l1, rsp_valid_l7;
  logic [31:0] rsp_data, rsp_data_l1, rsp_data_l7;
  logic        rsp_err, rsp_err_l1, rsp_err_l7;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_25020051_ifetch_sram #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_25020051_ifetch_sram #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_addr(req_addr),
    .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1), .rsp_data(rsp_data_l1), .rsp_err(rsp_err_l1),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_25020051_ifetch_sram #(.LATENCY(7)) dut_l7 (
    .clk(clk), .rst(rst), .req_valid(req_valid_l7), .req_ready(req_ready_l7), .req_addr(req_addr),
    .rsp_valid(rsp_valid_l7), .rsp_ready(rsp_ready_l7), .rsp_data(rsp_data_l7), .rsp_err(rsp_err_l7),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    step();
    ld_en = 1'b0;
    $display("[TB] load idx=%0d data=%08h", idx, data);
  endtask

  // Full transaction on the main instance: accept, count edges to rsp_valid, check, then retire.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err,
                       input string name);
    int edges;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = addr;
    step();
    req_valid = 1'b0;
    edges = 1;
    tests++;
    if (rsp_valid === 1'b0 && rsp_data !== 32'h0) begin
      fails++; $display("FAIL %s rsp_data while not valid: got %08h want 0", name, rsp_data);
    end
    while (rsp_valid !== 1'b1 && edges < 20) begin
      step(); edges++;
    end
    tests++;
    if (edges !== 2) begin
      fails++; $display("FAIL %s latency: got %0d edges want 2", name, edges);
    end
    tests++;
    if (rsp_data !== exp_data || rsp_err !== exp_err) begin
      fails++; $display("FAIL %s response: got data=%08h err=%b want data=%08h err=%b",
                        name, rsp_data, rsp_err, exp_data, exp_err);
    end
    $display("[TB] fetch %s addr=%08h data=%08h err=%b edges=%0d", name, addr, rsp_data, rsp_err, edges);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL %s retire: got valid=%b data=%08h err=%b ready=%b want 0 0 0 1",
                        name, rsp_valid, rsp_data, rsp_err, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_valid_l1 = 0; req_valid_l7 = 0;
    rsp_ready = 0; rsp_ready_l1 = 0; rsp_ready_l7 = 0;
    req_addr = 32'h0; ld_en = 0; ld_idx = 0; ld_data = 0;
    step(); step();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset_state: got ready=%b valid=%b data=%08h err=%b want 1 0 0 0",
                        req_ready, rsp_valid, rsp_data, rsp_err);
    end
    rst = 1'b0;
    step();
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    load(4'd0, 32'h00500093);
    load(4'd1, 32'h00000013);
    fetch(32'h80000004, 32'h00000013, 1'b0, "basic_idx1");
  endtask

  task automatic test_latency_variants();
    int edges;
    req_addr = 32'h80000004;
    req_valid_l1 = 1'b1; step(); req_valid_l1 = 1'b0;
    edges = 1;
    while (rsp_valid_l1 !== 1'b1 && edges < 20) begin step(); edges++; end
    tests++;
    if (edges !== 1 || rsp_data_l1 !== 32'h00000013) begin
      fails++; $display("FAIL latency1: got edges=%0d data=%08h want 1 00000013", edges, rsp_data_l1);
    end
    $display("[TB] latency1 edges=%0d data=%08h", edges, rsp_data_l1);
    rsp_ready_l1 = 1'b1; step(); rsp_ready_l1 = 1'b0;

    req_valid_l7 = 1'b1; step(); req_valid_l7 = 1'b0;
    edges = 1;
    while (rsp_valid_l7 !== 1'b1 && edges < 20) begin step(); edges++; end
    tests++;
    if (edges !== 7 || rsp_data_l7 !== 32'h00000013) begin
      fails++; $display("FAIL latency7: got edges=%0d data=%08h want 7 00000013", edges, rsp_data_l7);
    end
    $display("[TB] latency7 edges=%0d data=%08h", edges, rsp_data_l7);
    rsp_ready_l7 = 1'b1; step(); rsp_ready_l7 = 1'b0;
    tests++;
    if (req_ready_l1 !== 1'b1 || req_ready_l7 !== 1'b1) begin
      fails++; $display("FAIL latency_retire: got ready_l1=%b ready_l7=%b want 1 1", req_ready_l1, req_ready_l7);
    end
  endtask

  task automatic test_backpressure();
    int edges;
    req_valid = 1'b1; req_addr = 32'h80000000;
    step();
    // Keep req_valid asserted: it must be ignored in WAIT/RESP and on the completion edge.
    req_addr = 32'h80000004;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin step(); edges++; end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h00500093 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++; $display("FAIL backpressure_hold%0d: got valid=%b data=%08h err=%b ready=%b want 1 00500093 0 0",
                          i, rsp_valid, rsp_data, rsp_err, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL backpressure_release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    req_valid = 1'b0;
    $display("[TB] backpressure held 3 cycles, released");
  endtask

  task automatic test_addr_err();
`ifdef YSYX_25020051_IFETCH_ERR_CHECK_EN
    fetch(32'h80000002, 32'h00000000, 1'b1, "misaligned");
    fetch(32'h80000040, 32'h00000000, 1'b1, "out_of_range");
`else
    fetch(32'h80000002, 32'h00500093, 1'b0, "misaligned");
    fetch(32'h80000040, 32'h00500093, 1'b0, "out_of_range");
`endif
  endtask

  task automatic test_reset_wait();
    req_valid = 1'b1; req_addr = 32'h80000004;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    #2;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_async: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL reset_abort%0d: got valid=%b ready=%b want 0 1", i, rsp_valid, req_ready);
      end
    end
    $display("[TB] reset during WAIT aborted request");
    fetch(32'h80000000, 32'h00500093, 1'b0, "after_reset");
  endtask

  task automatic test_load_collision();
    int edges;
    req_valid = 1'b1; req_addr = 32'h80000000;
    ld_en = 1'b1; ld_idx = 4'd0; ld_data = 32'hDEADBEEF;
    step();
    req_valid = 1'b0; ld_en = 1'b0;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin step(); edges++; end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00500093) begin
      fails++; $display("FAIL load_collision: got valid=%b data=%08h want 1 00500093", rsp_valid, rsp_data);
    end
    $display("[TB] collision fetch data=%08h", rsp_data);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    fetch(32'h80000000, 32'hDEADBEEF, 1'b0, "after_collision");
  endtask

  task automatic test_late_load();
    int edges;
    req_valid = 1'b1; req_addr = 32'h80000004;
    step();
    req_valid = 1'b0;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin step(); edges++; end
    load(4'd1, 32'hCAFEF00D);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000013) begin
      fails++; $display("FAIL late_load: got valid=%b data=%08h want 1 00000013", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    fetch(32'h80000004, 32'hCAFEF00D, 1'b0, "after_late_load");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency_variants();
    test_backpressure();
    test_addr_err();
    test_reset_wait();
    test_load_collision();
    test_late_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
